// File: rtl/smvm_stream_tx_if.sv
// SMVM input bus: one word per cycle, qualified by in_valid.
// master = stream transmitter, slave = SMVM core (or a bench monitor).
interface smvm_stream_tx_if;
  logic [7:0] val_in;
  logic [2:0] col_in;
  logic       ipv_in;
  logic       in_valid;

  modport master (output val_in, col_in, ipv_in, in_valid);
  modport slave  (input  val_in, col_in, ipv_in, in_valid);
endinterface

// File: rtl/smvm_stream_tx.sv
// SMVM stream transmitter: holds one job (dense vector + nonzero list) and
// serialises it as ROW, COL, vector words, VAL/IDX pairs (padded to a multiple
// of K), an END terminator, then an idle gap so the core can drain.
module smvm_stream_tx #(
  parameter int K        = 4,
  parameter int MAX_COLS = 128,
  parameter int MAX_NNZ  = 256,
  parameter int GAP      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic                  i_wr_sel,
  input  logic [7:0]            i_wr_addr,
  input  logic [7:0]            i_wr_val,
  input  logic [7:0]            i_wr_col,
  input  logic                  i_wr_ipv,
  input  logic                  i_start,
  input  logic [7:0]            i_rows,
  input  logic [7:0]            i_cols,
  input  logic [8:0]            i_nnz,
  smvm_stream_tx_if.master      bus,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int VAW = $clog2(MAX_COLS);
  localparam int NAW = $clog2(MAX_NNZ);
  localparam logic [9:0] L_MAXC = 10'(MAX_COLS);
  localparam logic [9:0] L_MAXN = 10'(MAX_NNZ);
  localparam logic [9:0] L_K    = 10'(K);
  localparam logic [9:0] L_GAP  = 10'(GAP);

  typedef enum logic [2:0] {
    S_IDLE, S_ROW, S_COL, S_VEC, S_VAL, S_IDX, S_END, S_GAP
  } state_t;

  // Job buffers; no reset, contents are only meaningful once the host loads them.
  logic [7:0]  r_vec [MAX_COLS];
  logic [16:0] r_nz  [MAX_NNZ];   // {val[7:0], col[7:0], ipv}

  state_t      r_state, w_next;
  logic [9:0]  r_idx, w_idx_nxt;  // element index while streaming, gap counter afterwards
  logic [7:0]  r_rows, r_cols;
  logic [8:0]  r_nnz;
  logic [9:0]  r_nnz_p;
  logic        r_err;

  logic        w_bad, w_accept, w_busy, w_done, w_valid, w_pad;
  logic [9:0]  w_nnz_p;
  logic [11:0] w_f;               // packed bus word: {val_in, ipv_in, col_in}
  logic [7:0]  w_vec;
  logic [16:0] w_nz;

  assign w_bad   = (i_cols == 8'd0) || ({2'b0, i_cols} > L_MAXC) || ({1'b0, i_nnz} > L_MAXN);
  assign w_nnz_p = (({1'b0, i_nnz} + L_K - 10'd1) / L_K) * L_K;
  assign w_busy  = (r_state != S_IDLE) && !w_done;
  assign w_vec   = r_vec[r_idx[VAW-1:0]];
  assign w_nz    = r_nz[r_idx[NAW-1:0]];
  // Indices past the real list are pad entries and read as all-zero.
  assign w_pad   = r_idx >= {1'b0, r_nnz};

  // Host writes land only while no job is in flight; same-cycle start sees them.
  always_ff @(posedge clk) begin
    if (i_wr_en && !w_busy) begin
      if (!i_wr_sel) begin
        if ({2'b0, i_wr_addr} < L_MAXC) r_vec[i_wr_addr[VAW-1:0]] <= i_wr_val;
      end else if ({2'b0, i_wr_addr} < L_MAXN) begin
        r_nz[i_wr_addr[NAW-1:0]] <= {i_wr_val, i_wr_col, i_wr_ipv};
      end
    end
  end

  // State, index and job registers; reset aborts any job without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_rows  <= '0;
      r_cols  <= '0;
      r_nnz   <= '0;
      r_nnz_p <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_idx   <= w_idx_nxt;
      r_err   <= (r_state == S_IDLE) && i_start && w_bad;
      if (w_accept) begin
        r_rows  <= i_rows;
        r_cols  <= i_cols;
        r_nnz   <= i_nnz;
        r_nnz_p <= w_nnz_p;
      end
    end
  end

  // Next-state and bus word; every streaming state emits exactly one word.
  always_comb begin
    w_next    = r_state;
    w_idx_nxt = r_idx;
    w_f       = 12'd0;
    w_valid   = 1'b0;
    w_done    = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      S_IDLE: if (i_start && !w_bad) begin
        w_accept  = 1'b1;
        w_idx_nxt = '0;
        w_next    = S_ROW;
      end
      S_ROW: begin
        w_valid = 1'b1;
        w_f     = {4'd0, r_rows};
        w_next  = S_COL;
      end
      S_COL: begin
        w_valid = 1'b1;
        w_f     = {4'd0, r_cols};
        w_next  = S_VEC;
      end
      S_VEC: begin
        w_valid = 1'b1;
        w_f     = {w_vec, 4'd0};
        if (r_idx == {2'b0, r_cols} - 10'd1) begin
          w_idx_nxt = '0;
          w_next    = (r_nnz_p == 10'd0) ? S_END : S_VAL;
        end else begin
          w_idx_nxt = r_idx + 10'd1;
        end
      end
      S_VAL: begin
        w_valid = 1'b1;
        if (!w_pad) w_f = {w_nz[16:9], w_nz[0], 3'd0};
        w_next  = S_IDX;
      end
      S_IDX: begin
        w_valid = 1'b1;
        if (!w_pad) w_f = {4'd0, w_nz[8:1]};
        if (r_idx == r_nnz_p - 10'd1) begin
          w_idx_nxt = '0;
          w_next    = S_END;
        end else begin
          w_idx_nxt = r_idx + 10'd1;
          w_next    = S_VAL;
        end
      end
      S_END: begin
        w_idx_nxt = '0;
        w_next    = S_GAP;
      end
      S_GAP: if (r_idx == L_GAP - 10'd1) begin
        w_done    = 1'b1;
        w_idx_nxt = '0;
        w_next    = S_IDLE;
      end else begin
        w_idx_nxt = r_idx + 10'd1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.in_valid = w_valid;
  assign bus.val_in   = w_f[11:4];
  assign bus.ipv_in   = w_f[3];
  assign bus.col_in   = w_f[2:0];
  assign o_busy       = w_busy;
  assign o_done       = w_done;
  assign o_err        = r_err;

endmodule

// File: tb/tb_smvm_stream_tx.sv
// Bench for smvm_stream_tx: random jobs streamed against a word-list model
// built from the job contents, plus error, ignore, packing and reset cases.
module tb_smvm_stream_tx;
  localparam int K = 4, MAX_COLS = 128, MAX_NNZ = 256, GAP = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 0, wr_sel = 0, wr_ipv = 0, start = 0;
  logic [7:0] wr_addr = 0, wr_val = 0, wr_col = 0, rows = 0, cols = 0;
  logic [8:0] nnz = 0;
  logic busy, done, err;

  always #5 clk = ~clk;

  smvm_stream_tx_if bus();

  smvm_stream_tx #(.K(K), .MAX_COLS(MAX_COLS), .MAX_NNZ(MAX_NNZ), .GAP(GAP)) dut (
    .clk(clk), .rst(rst),
    .i_wr_en(wr_en), .i_wr_sel(wr_sel), .i_wr_addr(wr_addr), .i_wr_val(wr_val),
    .i_wr_col(wr_col), .i_wr_ipv(wr_ipv),
    .i_start(start), .i_rows(rows), .i_cols(cols), .i_nnz(nnz),
    .bus(bus), .o_busy(busy), .o_done(done), .o_err(err)
  );

  int n_checks = 0, n_fail = 0;

  // Reference job contents as the host believes them to be.
  logic [7:0] m_vec [MAX_COLS];
  logic [7:0] m_val [MAX_NNZ];
  logic [7:0] m_col [MAX_NNZ];
  logic       m_ipv [MAX_NNZ];

  logic [11:0] exp_q[$];
  logic [11:0] got_q[$];
  int first_at, done_gap;
  bit bubble, busy_bad, timed_out;

  task automatic host_write(input bit sel, input int addr, input logic [7:0] v,
                            input logic [7:0] c, input logic p, input bit upd);
    @(negedge clk);
    wr_en = 1; wr_sel = sel; wr_addr = addr[7:0]; wr_val = v; wr_col = c; wr_ipv = p;
    @(posedge clk); #1;
    wr_en = 0;
    if (upd) begin
      if (!sel) m_vec[addr] = v;
      else begin m_val[addr] = v; m_col[addr] = c; m_ipv[addr] = p; end
    end
  endtask

  task automatic load_random(input int nc, input int nz);
    for (int i = 0; i < nc; i++) host_write(0, i, 8'($urandom), 8'd0, 1'b0, 1);
    for (int j = 0; j < nz; j++)
      host_write(1, j, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1);
  endtask

  // Expected word list: header, vector, nonzero pairs padded with zero pairs.
  task automatic model_job(input int r, input int c, input int z);
    int zp;
    zp = ((z + K - 1) / K) * K;
    exp_q.delete();
    exp_q.push_back(12'(r));
    exp_q.push_back(12'(c));
    for (int i = 0; i < c; i++) exp_q.push_back({m_vec[i], 4'd0});
    for (int j = 0; j < zp; j++) begin
      if (j < z) begin
        exp_q.push_back({m_val[j], m_ipv[j], 3'd0});
        exp_q.push_back({4'd0, m_col[j]});
      end else begin
        exp_q.push_back(12'd0);
        exp_q.push_back(12'd0);
      end
    end
  endtask

  task automatic launch(input int r, input int c, input int z);
    @(negedge clk);
    start = 1; rows = 8'(r); cols = 8'(c); nnz = 9'(z);
    @(posedge clk); #1;
    start = 0;
  endtask

  // Records every valid word until done (cycle 1 = first cycle after start edge).
  task automatic collect(input int budget);
    int last;
    bit got_done;
    last = -1; got_done = 0;
    got_q.delete();
    first_at = -1; done_gap = -1; bubble = 0; busy_bad = 0; timed_out = 0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      if (bus.in_valid) begin
        if (last >= 0 && last != cyc - 1) bubble = 1;
        if (first_at < 0) first_at = cyc;
        last = cyc;
        got_q.push_back({bus.val_in, bus.ipv_in, bus.col_in});
      end
      if (done) begin
        done_gap = cyc - last;
        if (busy) busy_bad = 1;
        got_done = 1;
        break;
      end
      if (!busy) busy_bad = 1;
    end
    if (!got_done) timed_out = 1;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.in_valid, bus.val_in, bus.col_in, bus.ipv_in} !== 13'd0) begin
      n_fail++; $display("FAIL reset_bus: got %h expected 0", {bus.in_valid, bus.val_in, bus.col_in, bus.ipv_in});
    end
    n_checks++;
    if ({busy, done, err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_status: got %b expected 000", {busy, done, err});
    end
    rst = 0;
    @(negedge clk);
    n_checks++;
    if ({bus.in_valid, busy, done, err} !== 4'b0000) begin
      n_fail++; $display("FAIL post_reset_idle: got %b expected 0000", {bus.in_valid, busy, done, err});
    end
  endtask

  task automatic test_basic();
    host_write(0, 0, 8'd5, 8'd0, 1'b0, 1);
    host_write(0, 1, 8'hFF, 8'd0, 1'b0, 1);
    host_write(0, 2, 8'd7, 8'd0, 1'b0, 1);
    host_write(1, 0, 8'd3, 8'd0, 1'b0, 1);
    host_write(1, 1, 8'hFE, 8'd2, 1'b1, 1);
    host_write(1, 2, 8'd1, 8'd1, 1'b0, 1);
    host_write(1, 3, 8'd4, 8'd0, 1'b1, 1);
    model_job(2, 3, 4);
    launch(2, 3, 4);
    collect(200);
    n_checks++;
    if (timed_out) begin n_fail++; $display("FAIL basic_timeout: no done within 200 cycles"); end
    n_checks++;
    if (got_q.size() !== 13) begin n_fail++; $display("FAIL basic_count: got %0d expected 13", got_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[k] !== exp_q[k]) begin
        n_fail++; $display("FAIL basic_word %0d: got %h expected %h", k, got_q[k], exp_q[k]);
      end
    end
    n_checks++;
    if (got_q.size() > 4 && {got_q[0], got_q[1], got_q[3], got_q[6]} !== {12'h002, 12'h003, 12'hFF0, 12'h000}) begin
      n_fail++; $display("FAIL basic_fixed: got %h %h %h %h", got_q[0], got_q[1], got_q[3], got_q[6]);
    end
    n_checks++;
    if (first_at !== 1 || bubble || busy_bad) begin
      n_fail++; $display("FAIL basic_timing: first=%0d bubble=%0d busy_bad=%0d expected 1 0 0", first_at, bubble, busy_bad);
    end
    n_checks++;
    if (done_gap !== GAP + 1) begin n_fail++; $display("FAIL basic_done_gap: got %0d expected %0d", done_gap, GAP + 1); end
    @(negedge clk);
    n_checks++;
    if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 00", {done, busy}); end
  endtask

  task automatic test_pad();
    int nc;
    nc = $urandom_range(1, 10);
    load_random(nc, 5);
    model_job(9, nc, 5);
    launch(9, nc, 5);
    collect(300);
    n_checks++;
    if (timed_out || got_q.size() !== 2 + nc + 16) begin
      n_fail++; $display("FAIL pad_count: got %0d expected %0d (timeout=%0d)", got_q.size(), 2 + nc + 16, timed_out);
    end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[k] !== exp_q[k]) begin
        n_fail++; $display("FAIL pad_word %0d: got %h expected %h", k, got_q[k], exp_q[k]);
      end
    end
    for (int k = got_q.size() - 6; k >= 0 && k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[k] !== 12'd0) begin n_fail++; $display("FAIL pad_zero %0d: got %h expected 000", k, got_q[k]); end
    end
    n_checks++;
    if (bubble || busy_bad || done_gap !== GAP + 1) begin
      n_fail++; $display("FAIL pad_timing: bubble=%0d busy_bad=%0d gap=%0d", bubble, busy_bad, done_gap);
    end
  endtask

  task automatic test_errors();
    int bad_c[3] = '{0, 8, 129};
    int bad_z[3] = '{4, 257, 0};
    int errs, errs_at1, vld, bsy;
    for (int t = 0; t < 3; t++) begin
      errs = 0; errs_at1 = 0; vld = 0; bsy = 0;
      launch(1, bad_c[t], bad_z[t]);
      for (int cyc = 1; cyc <= 6; cyc++) begin
        @(negedge clk);
        if (err) begin errs++; if (cyc == 1) errs_at1 = 1; end
        if (bus.in_valid) vld++;
        if (busy) bsy++;
      end
      n_checks++;
      if (errs !== 1 || errs_at1 !== 1) begin
        n_fail++; $display("FAIL err_pulse cols=%0d nnz=%0d: pulses=%0d at_cycle1=%0d expected 1 1", bad_c[t], bad_z[t], errs, errs_at1);
      end
      n_checks++;
      if (vld !== 0 || bsy !== 0) begin
        n_fail++; $display("FAIL err_quiet cols=%0d nnz=%0d: valid=%0d busy=%0d expected 0 0", bad_c[t], bad_z[t], vld, bsy);
      end
    end
  endtask

  task automatic test_ignore();
    int extra;
    logic [7:0] old10;
    load_random(20, 4);
    old10 = m_vec[10];
    model_job(3, 20, 4);
    launch(3, 20, 4);
    fork
      collect(400);
      begin
        repeat (5) @(negedge clk);
        host_write(0, 10, ~old10, 8'd0, 1'b0, 0);
      end
      begin
        bit seen;
        seen = 0;
        for (int c = 0; c < 400; c++) begin
          @(negedge clk);
          if (bus.in_valid) seen = 1;
          else if (seen) break;
        end
        repeat (3) @(negedge clk);
        launch(1, 2, 0);
      end
    join
    n_checks++;
    if (timed_out || got_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL ignore_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[k] !== exp_q[k]) begin
        n_fail++; $display("FAIL ignore_word %0d: got %h expected %h", k, got_q[k], exp_q[k]);
      end
    end
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.in_valid || busy || err) extra++;
    end
    n_checks++;
    if (extra !== 0) begin n_fail++; $display("FAIL ignore_gap_start: active cycles %0d expected 0", extra); end
    launch(3, 20, 4);
    collect(400);
    n_checks++;
    if (got_q.size() > 12 && got_q[12] !== {old10, 4'd0}) begin
      n_fail++; $display("FAIL ignore_write: vec10 word got %h expected %h", got_q[12], {old10, 4'd0});
    end
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL ignore_rerun_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_packing();
    host_write(1, 0, 8'h55, 8'h9A, 1'b0, 1);
    // Write and start share one cycle: the job must see the new vector word.
    @(negedge clk);
    wr_en = 1; wr_sel = 0; wr_addr = 0; wr_val = 8'h3C;
    start = 1; rows = 8'd200; cols = 8'd1; nnz = 9'd1;
    @(posedge clk); #1;
    wr_en = 0; start = 0;
    m_vec[0] = 8'h3C;
    model_job(200, 1, 1);
    collect(200);
    n_checks++;
    if (got_q.size() !== 2 + 1 + 8) begin n_fail++; $display("FAIL pack_count: got %0d expected 11", got_q.size()); end
    n_checks++;
    if (got_q.size() > 0 && got_q[0] !== 12'h0C8) begin
      n_fail++; $display("FAIL pack_rows: val=%h ipv=%b col=%b expected val=0c ipv=1 col=000", got_q[0][11:4], got_q[0][3], got_q[0][2:0]);
    end
    n_checks++;
    if (got_q.size() > 2 && got_q[2] !== 12'h3C0) begin n_fail++; $display("FAIL pack_same_cycle_write: got %h expected 3c0", got_q[2]); end
    n_checks++;
    if (got_q.size() > 4 && {got_q[4][11:4], got_q[4][3], got_q[4][2:0]} !== {8'h09, 1'b1, 3'b010}) begin
      n_fail++; $display("FAIL pack_idx: val=%h ipv=%b col=%b expected val=09 ipv=1 col=010", got_q[4][11:4], got_q[4][3], got_q[4][2:0]);
    end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[k] !== exp_q[k]) begin
        n_fail++; $display("FAIL pack_word %0d: got %h expected %h", k, got_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cnt, bad;
    load_random(4, 8);
    launch(5, 4, 8);
    cnt = 0;
    for (int c = 0; c < 100 && cnt < 2 + 4 + 1; c++) begin
      @(negedge clk);
      if (bus.in_valid) cnt++;
    end
    n_checks++;
    if (cnt !== 7) begin n_fail++; $display("FAIL rst_mid_reach: words %0d expected 7", cnt); end
    rst = 1;
    @(negedge clk);
    n_checks++;
    if ({bus.in_valid, busy, done} !== 3'b000) begin
      n_fail++; $display("FAIL rst_mid_abort: got %b expected 000", {bus.in_valid, busy, done});
    end
    rst = 0;
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || bus.in_valid || busy) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL rst_mid_no_done: active cycles %0d expected 0", bad); end
    load_random(4, 8);
    model_job(5, 4, 8);
    launch(5, 4, 8);
    collect(200);
    n_checks++;
    if (timed_out || got_q.size() !== exp_q.size() || bubble || done_gap !== GAP + 1) begin
      n_fail++; $display("FAIL rst_mid_next: words %0d expected %0d gap %0d", got_q.size(), exp_q.size(), done_gap);
    end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[k] !== exp_q[k]) begin
        n_fail++; $display("FAIL rst_mid_word %0d: got %h expected %h", k, got_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_random();
    int nc, nz, r, errs;
    for (int it = 0; it < 6; it++) begin
      nc = (it == 5) ? MAX_COLS : $urandom_range(1, 16);
      nz = (it == 0) ? 0 : (it == 5) ? MAX_NNZ : $urandom_range(1, 20);
      r  = $urandom_range(0, 255);
      load_random(nc, nz);
      model_job(r, nc, nz);
      launch(r, nc, nz);
      collect(1000);
      n_checks++;
      if (timed_out || got_q.size() !== exp_q.size()) begin
        n_fail++; $display("FAIL rand_count it%0d: got %0d expected %0d", it, got_q.size(), exp_q.size());
      end
      errs = 0;
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
        if (got_q[k] !== exp_q[k]) begin
          if (errs == 0) $display("FAIL rand_word it%0d[%0d]: got %h expected %h", it, k, got_q[k], exp_q[k]);
          errs++;
        end
      n_checks++;
      if (errs !== 0) n_fail++;
      n_checks++;
      if (first_at !== 1 || bubble || busy_bad || done_gap !== GAP + 1) begin
        n_fail++; $display("FAIL rand_timing it%0d: first=%0d bubble=%0d busy_bad=%0d gap=%0d", it, first_at, bubble, busy_bad, done_gap);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pad();
    test_errors();
    test_ignore();
    test_packing();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
